approx_product_expander: RTL and testbench
==========================================

// Module: approx_product_expander
// PURPOSE
//  Back end of the approximate multiplier path, and the inverse of operand normalisation.
//  The normaliser shifts each operand left to its leading one and keeps the leading-zero counts.
//  This block takes the 2*MANT_WIDTH-bit mantissa product plus both leading-zero counts.
//  It shifts the product right, one bit per cycle, to rebuild the 4*MANT_WIDTH-bit result.
//  Valid/ready on both sides; it sits between the mantissa multiplier and the result consumer.
// PARAMETERS
//  MANT_WIDTH  8  operand mantissa width; product is 2*MANT_WIDTH, result is 4*MANT_WIDTH
//  LZ_WIDTH    5  width of each leading-zero count; must hold 2*MANT_WIDTH
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               synchronous, active-high reset
//  in_valid   in   1               mant/lz_a/lz_b are valid
//  in_ready   out  1               block can accept an input this cycle
//  mant       in   2*MANT_WIDTH    mantissa product (normalised operands' top bits multiplied)
//  lz_a       in   LZ_WIDTH        leading-zero count of operand A; value 2*MANT_WIDTH means A==0
//  lz_b       in   LZ_WIDTH        leading-zero count of operand B; value 2*MANT_WIDTH means B==0
//  out_valid  out  1               result is valid and held until out_ready
//  out_ready  in   1               consumer takes result
//  result     out  4*MANT_WIDTH    approximate product
// BEHAVIOUR
//  Function: result = {mant, {2*MANT_WIDTH{1'b0}}} >> (lz_a + lz_b), logical shift.
//  Zero rule: result = 0 if lz_a >= 2*MANT_WIDTH or lz_b >= 2*MANT_WIDTH (counts above the max are treated as zero).
//  Shift count: sum held in LZ_WIDTH+1 bits; maximum legal shift is 2*(2*MANT_WIDTH-1) = 30.
//  States (2-bit): IDLE, SHIFT, DONE.
//  Reset: state IDLE; result reg 0; count 0; in_ready 1; out_valid 0.
//  IDLE
//   - in_ready=1.
//   - in_valid at edge T: load {mant, 0} into the result reg and count = lz_a + lz_b.
//   - zero rule true: load 0 instead of {mant, 0}.
//   - next state: DONE if zero rule or count==0, else SHIFT.
//  SHIFT
//   - in_ready=0.
//   - each cycle: reg <= reg >> 1; count <= count - 1.
//   - count==1 at the edge goes to DONE, so exactly (lz_a + lz_b) shifts happen.
//  DONE
//   - out_valid=1; result = reg, stable while out_ready=0.
//   - out_ready=1 at an edge: go to IDLE, out_valid drops next cycle.
//   - in_ready stays 0 in DONE; no accept in the same cycle as the hand-off.
//  Latency: out_valid first high at cycle T+1+(lz_a+lz_b); zero case at T+1.
//  in_valid outside IDLE is ignored; the input is not captured.
//  rst asserted in any state: returns to the reset values at the next edge and the in-flight result is dropped.
//  result is the register output, 0 from reset until the first load; the consumer samples it only when out_valid=1.
// STRUCTURE
//  Shared package
//   - state encoding localparams (ST_IDLE=0, ST_SHIFT=1, ST_DONE=2).
//   - width constants PROD_W = 2*MANT_WIDTH and RES_W = 4*MANT_WIDTH.
//  Sub-module right_shift_register #(WIDTH)
//   - ports: clk, rst, load, shift_en, in, in_sh, out; logical right shift, in_sh = 0 here.
//   - mirrors the existing left ShiftRegister.
//  Also in this block: a loadable down-counter, the FSM, and the zero-detect compare.
// TESTING
//  1. mant=16'h8000, lz_a=0, lz_b=0 -> result 32'h8000_0000, out_valid at T+1.
//  2. mant=16'h9000, lz_a=3, lz_b=5 -> result 32'h0090_0000, out_valid at T+9.
//  3. mant=16'hFFFF, lz_a=15, lz_b=15 -> result 32'h0000_0003, out_valid at T+31.
//  4. lz_a=16, mant=16'hABCD -> result 0, out_valid at T+1.
//  5. Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0, a second in_valid is not taken.
//     Then out_ready=1 -> IDLE next cycle, in_ready=1.
//  6. rst=1 for one cycle mid-SHIFT (case 3, cycle T+10) -> next cycle IDLE, out_valid=0, result=0.
//     A new input is then processed correctly.

Source files
------------

// File: rtl/approx_product_expander_pkg.sv
// rtl/approx_product_expander_pkg.sv - shared constants and state type for the product expander
package approx_product_expander_pkg;

    localparam int MANT_W_DEF = 8;
    localparam int LZ_W_DEF   = 5;
    localparam int PROD_W     = 2 * MANT_W_DEF;
    localparam int RES_W      = 4 * MANT_W_DEF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/approx_product_expander_if.sv
// rtl/approx_product_expander_if.sv - valid/ready bundle between multiplier, expander and consumer
interface approx_product_expander_if #(
    parameter int MANT_WIDTH = 8,
    parameter int LZ_WIDTH   = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [2*MANT_WIDTH-1:0]   mant;
    logic [LZ_WIDTH-1:0]       lz_a;
    logic [LZ_WIDTH-1:0]       lz_b;
    logic                      out_valid;
    logic                      out_ready;
    logic [4*MANT_WIDTH-1:0]   result;

    // Upstream producer and downstream consumer side
    modport master (
        output in_valid, mant, lz_a, lz_b, out_ready,
        input  in_ready, out_valid, result
    );

    // Expander side
    modport slave (
        input  in_valid, mant, lz_a, lz_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/approx_product_expander_right_shift_register.sv
// rtl/approx_product_expander_right_shift_register.sv - loadable logical right shift register
module right_shift_register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] in,
    input  logic             in_sh,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load wins over shift; in_sh enters at the MSB
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = in;
        end else if (shift_en) begin
            data_d = {in_sh, data_q[WIDTH-1:1]};
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;

endmodule

// File: rtl/approx_product_expander.sv
// rtl/approx_product_expander.sv - rebuilds the full product by shifting right by both leading-zero counts
module approx_product_expander
    import approx_product_expander_pkg::*;
#(
    parameter int MANT_WIDTH = MANT_W_DEF,
    parameter int LZ_WIDTH   = LZ_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    approx_product_expander_if.slave bus
);

    localparam int PW    = 2 * MANT_WIDTH;
    localparam int RW    = 4 * MANT_WIDTH;
    localparam int CNT_W = LZ_WIDTH + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [CNT_W-1:0]   shift_sum;
    logic               zero_rule;
    logic               sr_load;
    logic               sr_shift;
    logic [RW-1:0]      sr_in;
    logic [RW-1:0]      sr_out;

    // A count equal to PW flags a zero operand; larger counts are treated the same way
    always_comb begin
        shift_sum = {1'b0, bus.lz_a} + {1'b0, bus.lz_b};
        zero_rule = ({1'b0, bus.lz_a} >= CNT_W'(PW)) || ({1'b0, bus.lz_b} >= CNT_W'(PW));
        sr_in     = zero_rule ? '0 : {bus.mant, {PW{1'b0}}};
    end

    // Next-state, counter and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sr_load    = 1'b1;
                    count_d    = shift_sum;
                    in_ready_d = 1'b0;
                    if (zero_rule || (shift_sum == '0)) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                sr_shift = 1'b1;
                count_d  = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                count_d     = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state, counter and output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    right_shift_register #(
        .WIDTH (RW)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .shift_en (sr_shift),
        .in       (sr_in),
        .in_sh    (1'b0),
        .out      (sr_out)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = sr_out;

endmodule

// File: tb/tb_approx_product_expander.sv
// tb/tb_approx_product_expander.sv - directed and randomized checks of the product expander
module tb_approx_product_expander;
    import approx_product_expander_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    approx_product_expander_if #(.MANT_WIDTH(MANT_W_DEF), .LZ_WIDTH(LZ_W_DEF)) bus ();

    approx_product_expander #(
        .MANT_WIDTH (MANT_W_DEF),
        .LZ_WIDTH   (LZ_W_DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] ref_result(input logic [PROD_W-1:0] m,
                                                    input int a, input int b);
        logic [RES_W-1:0] full;
        full = {m, {PROD_W{1'b0}}};
        if (a >= PROD_W || b >= PROD_W) return '0;
        return full >> (a + b);
    endfunction

    function automatic int ref_latency(input int a, input int b);
        if (a >= PROD_W || b >= PROD_W) return 1;
        return 1 + a + b;
    endfunction

    // Present one input, measure the cycle out_valid first rises, check result, then hand off
    task automatic run_txn(input string tag, input logic [PROD_W-1:0] m, input int a, input int b);
        int lat;
        int waited;
        lat = -1;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        bus.mant     = m;
        bus.lz_a     = LZ_W_DEF'(a);
        bus.lz_b     = LZ_W_DEF'(b);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(ref_latency(a, b)));
        check({tag, "_res"}, 64'(bus.result), 64'(ref_result(m, a, b)));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ov_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [RES_W-1:0] held;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mant      = '0;
        bus.lz_a      = '0;
        bus.lz_b      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);

        run_txn("t1", 16'h8000, 0, 0);
        check("t1_const", 64'(ref_result(16'h8000, 0, 0)), 64'h8000_0000);
        run_txn("t2", 16'h9000, 3, 5);
        run_txn("t3", 16'hFFFF, 15, 15);
        run_txn("t4", 16'hABCD, 16, 2);
        run_txn("t4b", 16'hABCD, 3, 31);

        // Hold the result in DONE while a competing input is offered
        bus.mant = 16'hC3A5; bus.lz_a = 5'd2; bus.lz_b = 5'd1; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.mant = 16'h1234; bus.lz_a = 5'd0; bus.lz_b = 5'd0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("t5_valid", 64'(bus.out_valid), 64'd1);
        held = bus.result;
        check("t5_res", 64'(held), 64'(ref_result(16'hC3A5, 2, 1)));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_hold_valid", 64'(bus.out_valid), 64'd1);
            check("t5_hold_res", 64'(bus.result), 64'(held));
            check("t5_hold_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("t5_idle_ready", 64'(bus.in_ready), 64'd1);
        check("t5_idle_valid", 64'(bus.out_valid), 64'd0);
        check("t5_not_taken", 64'(bus.result), 64'(held));

        // Reset in the middle of a long shift
        bus.mant = 16'hFFFF; bus.lz_a = 5'd15; bus.lz_b = 5'd15; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 64'(bus.out_valid), 64'd0);
        check("t6_res", 64'(bus.result), 64'd0);
        check("t6_ready", 64'(bus.in_ready), 64'd1);
        run_txn("t6_after", 16'h4321, 4, 7);

        // Randomized operands, including counts beyond the zero marker
        for (int i = 0; i < 40; i++) begin
            logic [PROD_W-1:0] m;
            int a;
            int b;
            m = PROD_W'($urandom);
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            b = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            run_txn($sformatf("rnd%0d", i), m, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
